frame_buffer_reader: RTL and testbench
======================================

# frame_buffer_reader

- Streams one monochrome video frame out of block RAM as a pixel-per-handshake stream for the VGA pixel pipeline.
- Sits between the frame store (single-cycle-latency synchronous-read RAM port, written by the frame decoder) and the VGA timing/output stage.
- Packed 1-bit pixels are fetched word by word and serialised MSB first.
- A two-word prefetch buffer hides RAM read latency, so the consumer can take one pixel every clock.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- WORD_WIDTH, 16, pixels per RAM word; H_ACTIVE*V_ACTIVE must be a multiple of WORD_WIDTH
- ADDR_WIDTH, 15, RAM word-address width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous active-high reset
- frame_start  in  1  single-cycle pulse; begin streaming the frame at frame_base
- frame_base  in  ADDR_WIDTH  word address of the frame's first word; sampled only when frame_start=1
- ram_rd_en  out  1  read request to the RAM port
- ram_addr  out  ADDR_WIDTH  read word address
- ram_q  in  WORD_WIDTH  read data, valid the cycle after ram_rd_en
- pix_out  out  1  current pixel (1 = white)
- pix_valid  out  1  pix_out holds a real pixel
- pix_ready  in  1  consumer takes the pixel; a transfer occurs when pix_valid & pix_ready
- frame_done  out  1  one-cycle pulse after the last pixel transfers
- underflow  out  1  sticky flag: pix_ready=1 while pix_valid=0 in STREAM
- busy  out  1  high in FILL or STREAM

## Operation
- Derived constant: WORDS = H_ACTIVE*V_ACTIVE/WORD_WIDTH.
- Counters:
  - rd_idx: words issued, 0..WORDS.
  - pix_cnt: pixels transferred, 0..H_ACTIVE*V_ACTIVE.
  - bit_idx: position inside the current word.
- Address rule: ram_addr = frame_base_latched + rd_idx, truncated to ADDR_WIDTH, so addresses wrap modulo 2^ADDR_WIDTH.
- State IDLE (reset state):
  - No reads; pix_valid=0.
  - frame_start → FILL.
- frame_start handling:
  - Latch frame_base; clear rd_idx, pix_cnt, bit_idx, the buffer and underflow.
  - Go to FILL.
- State FILL: issue reads until the first word is captured, then → STREAM.
- State STREAM:
  - pix_out = current word bit [WORD_WIDTH-1-bit_idx].
  - On each transfer, increment bit_idx.
  - When bit_idx wraps from WORD_WIDTH-1 to 0, pop the next buffered word.
- Prefetch buffer (2 words):
  - Issue a read (ram_rd_en=1) in any cycle where occupancy + in-flight reads < 2 and rd_idx < WORDS.
  - At most one read is in flight; at most one read is issued per cycle.
  - Returned ram_q is written into the buffer the cycle it is valid.
- End of frame:
  - rd_idx == WORDS: no further reads.
  - The transfer of pixel H_ACTIVE*V_ACTIVE-1 → frame_done=1 the next cycle, pix_valid=0, state DONE.
- State DONE: idle outputs; frame_start → FILL.
- Restart and abort:
  - frame_start in any state (FILL, STREAM, DONE) restarts immediately.
  - A read in flight when frame_start is sampled is discarded; its ram_q is never buffered.
  - frame_start coinciding with a transfer: the transfer is lost; the restart wins.
- Underflow:
  - Set only in STREAM when pix_ready=1 and pix_valid=0.
  - Cleared by rst or frame_start.

## Timing
- Reset values: ram_rd_en=0, ram_addr=0, pix_out=0, pix_valid=0, frame_done=0, underflow=0, busy=0, state IDLE.
- All outputs are registered.
- Startup sequence, with frame_start sampled at edge 0:
  - cycle 1: ram_rd_en=1, ram_addr=base.
  - cycle 2: ram_q valid; second read issued (ram_addr=base+1).
  - cycle 3: pix_valid=1, pixel 0 on pix_out.
- Latency from frame_start to first pix_valid: 3 cycles.
- Throughput:
  - With pix_ready held high, one pixel transfers per cycle with no pix_valid gaps for WORD_WIDTH ≥ 2.
  - Underflow never sets in that case.
- pix_out and pix_valid stay stable while pix_valid=1 and pix_ready=0.
- frame_done is high for exactly one cycle, the cycle after the final transfer.
- busy drops in that same cycle.
- rst asserted in any cycle → reset values at the next edge; an in-flight read is ignored.

## Test plan
Use H_ACTIVE=8, V_ACTIVE=2, WORD_WIDTH=4, ADDR_WIDTH=4 (WORDS=4), RAM words 0xA, 0x5, 0xF, 0x0 at base 3.
- Basic streaming:
  - Stimulus: rst, then frame_start with base=3, pix_ready=1 throughout.
  - Required: reads at addresses 3, 4, 5, 6 only; pix_valid from cycle 3.
  - Required pixels: 1010 0101 1111 0000; frame_done pulse in the cycle after the 16th transfer; underflow=0.
- Consumer stalls:
  - Stimulus: pix_ready toggled 1,0,0,1,…
  - Required: same 16-pixel sequence, no pixel repeated or skipped, never more than 2 words buffered, underflow=0.
- Address wrap:
  - Stimulus: base=14.
  - Required: read addresses 14, 15, 0, 1.
- Restart mid-frame:
  - Stimulus: frame_start after 6 transfers, with a read in flight.
  - Required: the stale word is dropped; streaming restarts at pixel 0 (1010…); pix_cnt restarts; 16 further transfers occur before frame_done.
- Underflow:
  - Stimulus: pix_ready=1 during FILL, then a RAM model stalled (delayed) so the buffer drains in STREAM.
  - Required: no flag during FILL; underflow=1 and sticky once starved in STREAM; cleared by the next frame_start.
- Reset mid-stream:
  - Stimulus: rst after 9 transfers.
  - Required: all outputs at reset values next cycle, state IDLE, no reads until the next frame_start.

Source files
------------

// File: rtl/frame_buffer_reader.sv
// rtl/frame_buffer_reader.sv - streams a packed 1-bit frame from block RAM as a pixel handshake stream
// A two-word prefetch buffer (current word + next word) hides the one-cycle RAM read latency.
module frame_buffer_reader #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int WORD_WIDTH = 16,
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic [ADDR_WIDTH-1:0] frame_base,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [WORD_WIDTH-1:0] ram_q,
    output logic                  pix_out,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  frame_done,
    output logic                  underflow,
    output logic                  busy
);

    localparam int PIXELS = H_ACTIVE * V_ACTIVE;
    localparam int WORDS  = PIXELS / WORD_WIDTH;
    localparam int RW     = $clog2(WORDS + 1);
    localparam int PW     = $clog2(PIXELS + 1);
    localparam int BW     = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

    localparam logic [RW-1:0] WORDS_C  = RW'(WORDS);
    localparam logic [PW-1:0] LAST_PIX = PW'(PIXELS - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WORD_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM,
        DONE
    } state_t;

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   base_l, base_n;
    logic [RW-1:0]           rd_idx, rd_idx_n;
    logic [PW-1:0]           pix_cnt, pix_cnt_n;
    logic [BW-1:0]           bit_idx, bit_idx_n;
    logic [WORD_WIDTH-1:0]   cur_word, cur_word_n;
    logic [WORD_WIDTH-1:0]   nxt_word, nxt_word_n;
    logic                    cur_valid, cur_valid_n;
    logic                    nxt_valid, nxt_valid_n;
    logic                    pend, pend_n;
    logic                    rd_en_n;
    logic [ADDR_WIDTH-1:0]   addr_n;
    logic                    pix_out_n;
    logic                    pix_valid_n;
    logic                    frame_done_n;
    logic                    underflow_n;
    logic                    busy_n;
    logic [1:0]              fill_cnt;
    logic                    xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            base_l     <= '0;
            rd_idx     <= '0;
            pix_cnt    <= '0;
            bit_idx    <= '0;
            cur_word   <= '0;
            nxt_word   <= '0;
            cur_valid  <= 1'b0;
            nxt_valid  <= 1'b0;
            pend       <= 1'b0;
            ram_rd_en  <= 1'b0;
            ram_addr   <= '0;
            pix_out    <= 1'b0;
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            underflow  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            base_l     <= base_n;
            rd_idx     <= rd_idx_n;
            pix_cnt    <= pix_cnt_n;
            bit_idx    <= bit_idx_n;
            cur_word   <= cur_word_n;
            nxt_word   <= nxt_word_n;
            cur_valid  <= cur_valid_n;
            nxt_valid  <= nxt_valid_n;
            pend       <= pend_n;
            ram_rd_en  <= rd_en_n;
            ram_addr   <= addr_n;
            pix_out    <= pix_out_n;
            pix_valid  <= pix_valid_n;
            frame_done <= frame_done_n;
            underflow  <= underflow_n;
            busy       <= busy_n;
        end
    end

    always_comb begin
        state_n      = state;
        base_n       = base_l;
        rd_idx_n     = rd_idx;
        pix_cnt_n    = pix_cnt;
        bit_idx_n    = bit_idx;
        cur_word_n   = cur_word;
        nxt_word_n   = nxt_word;
        cur_valid_n  = cur_valid;
        nxt_valid_n  = nxt_valid;
        pend_n       = 1'b0;
        rd_en_n      = 1'b0;
        addr_n       = ram_addr;
        pix_out_n    = 1'b0;
        pix_valid_n  = 1'b0;
        frame_done_n = 1'b0;
        underflow_n  = underflow;
        busy_n       = 1'b0;
        fill_cnt     = 2'd0;
        xfer         = pix_valid & pix_ready;

        if (frame_start) begin
            // Restart wins over any transfer; the read in flight is dropped by clearing pend.
            state_n     = FILL;
            base_n      = frame_base;
            rd_idx_n    = RW'(1);
            pix_cnt_n   = '0;
            bit_idx_n   = '0;
            cur_valid_n = 1'b0;
            nxt_valid_n = 1'b0;
            underflow_n = 1'b0;
            rd_en_n     = 1'b1;
            addr_n      = frame_base;
            busy_n      = 1'b1;
        end else if (state == FILL || state == STREAM) begin
            busy_n = 1'b1;
            if (state == STREAM && pix_ready && !pix_valid) begin
                underflow_n = 1'b1;
            end

            if (xfer && pix_cnt == LAST_PIX) begin
                state_n      = DONE;
                busy_n       = 1'b0;
                frame_done_n = 1'b1;
                pix_cnt_n    = pix_cnt + PW'(1);
                cur_valid_n  = 1'b0;
                nxt_valid_n  = 1'b0;
            end else begin
                if (xfer) begin
                    pix_cnt_n = pix_cnt + PW'(1);
                    if (bit_idx == LAST_BIT) begin
                        bit_idx_n   = '0;
                        cur_word_n  = nxt_word;
                        cur_valid_n = nxt_valid;
                        nxt_valid_n = 1'b0;
                    end else begin
                        bit_idx_n = bit_idx + BW'(1);
                    end
                end

                // Returning word lands in whichever slot is free after this cycle's pop.
                if (pend) begin
                    if (!cur_valid_n) begin
                        cur_word_n  = ram_q;
                        cur_valid_n = 1'b1;
                    end else begin
                        nxt_word_n  = ram_q;
                        nxt_valid_n = 1'b1;
                    end
                end

                pend_n   = ram_rd_en;
                fill_cnt = {1'b0, cur_valid_n} + {1'b0, nxt_valid_n} + {1'b0, ram_rd_en};
                if (fill_cnt < 2'd2 && rd_idx < WORDS_C) begin
                    rd_en_n  = 1'b1;
                    addr_n   = base_l + ADDR_WIDTH'(rd_idx);
                    rd_idx_n = rd_idx + RW'(1);
                end

                if (state == FILL && cur_valid_n) begin
                    state_n = STREAM;
                end
                pix_valid_n = cur_valid_n && (state_n == STREAM);
                pix_out_n   = cur_word_n[LAST_BIT - bit_idx_n];
            end
        end
    end

endmodule

// File: tb/tb_frame_buffer_reader.sv
// tb/tb_frame_buffer_reader.sv - self-checking bench for frame_buffer_reader
// Main instance uses an 8x2 frame of 4-bit words; a 1-bit-word instance exercises starvation.
module tb_frame_buffer_reader;

    localparam int NPIX = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_start;
    logic [3:0] frame_base;
    logic       ram_rd_en;
    logic [3:0] ram_addr;
    logic [3:0] ram_q = '0;
    logic       pix_out, pix_valid, pix_ready, frame_done, underflow, busy;

    logic       fs1, ready1, rd_en1, pix1, valid1, done1, uf1, busy1;
    logic [3:0] base1, addr1;
    logic [0:0] q1 = '0;

    logic [3:0] mem [16];
    logic       mem1 [16];

    int tests = 0;
    int fails = 0;

    frame_buffer_reader #(.H_ACTIVE(8), .V_ACTIVE(2), .WORD_WIDTH(4), .ADDR_WIDTH(4)) u_dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .frame_base(frame_base),
        .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_q(ram_q),
        .pix_out(pix_out), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .frame_done(frame_done), .underflow(underflow), .busy(busy)
    );

    frame_buffer_reader #(.H_ACTIVE(8), .V_ACTIVE(2), .WORD_WIDTH(1), .ADDR_WIDTH(4)) u_dut1 (
        .clk(clk), .rst(rst), .frame_start(fs1), .frame_base(base1),
        .ram_rd_en(rd_en1), .ram_addr(addr1), .ram_q(q1),
        .pix_out(pix1), .pix_valid(valid1), .pix_ready(ready1),
        .frame_done(done1), .underflow(uf1), .busy(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_rd_en) ram_q <= mem[ram_addr];
    always @(posedge clk) if (rd_en1) q1 <= mem1[addr1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic exp_pix(input int b, input int k);
        logic [3:0] w;
        w = mem[(b + k / 4) % 16];
        return w[3 - (k % 4)];
    endfunction

    // Reference model: what the stream must look like, from frame-level bookkeeping only.
    logic mon_en = 1'b0;
    int   m_base = 0, m_rd = 0, m_x = 0;
    bit   m_active = 0, m_due = 0, m_hold = 0;
    logic m_prev = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_frame_done", frame_done, m_due);
            chk("mon_busy", busy, m_active);
            chk("mon_underflow", underflow, 0);
            if (ram_rd_en) begin
                chk("mon_rd_active", m_active, 1);
                chk("mon_rd_count", m_rd < 4, 1);
                chk("mon_rd_addr", ram_addr, (m_base + m_rd) % 16);
                m_rd++;
                chk("mon_buffered", (m_rd - m_x / 4) <= 2, 1);
            end
            if (pix_valid) begin
                chk("mon_valid_window", m_active && m_x < NPIX, 1);
                chk("mon_pix", pix_out, exp_pix(m_base, m_x));
            end
            if (m_hold) begin
                chk("mon_hold_valid", pix_valid, 1);
                chk("mon_hold_pix", pix_out, m_prev);
            end
            m_hold = pix_valid && !pix_ready && !frame_start && !rst;
            m_prev = pix_out;
            m_due  = 0;
            if (rst) begin
                m_active = 0; m_rd = 0; m_x = 0;
            end else if (frame_start) begin
                m_active = 1; m_base = int'(frame_base); m_rd = 0; m_x = 0;
            end else if (pix_valid && pix_ready) begin
                m_x++;
                if (m_x == NPIX) begin
                    m_due = 1; m_active = 0;
                end
            end
        end
    end

    logic [15:0] r_pv;
    int          r_nx, r_first, r_done, r_last, r_nrd;
    bit          r_restarted;
    logic [3:0]  r_addr [8];

    function automatic logic ready_pat(input int c);
        case (c % 4)
            0: return 1'b1;
            1: return 1'b0;
            2: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic run_frame(input logic [3:0] b, input int mode, input int restart_at);
        int cyc, fcyc;
        bit rs;
        r_pv = '0; r_nx = 0; r_first = -1; r_done = -1; r_last = -1; r_nrd = 0; r_restarted = 0;
        frame_start = 1'b1; frame_base = b; pix_ready = 1'b1;
        cyc = 0; fcyc = 0;
        while (cyc < 400 && r_done < 0) begin
            rs = 0;
            if (cyc > 0) begin
                frame_start = 1'b0;
                if (restart_at > 0 && !r_restarted && r_nx >= restart_at && ram_rd_en) begin
                    frame_start = 1'b1; rs = 1; r_restarted = 1;
                end
                pix_ready = (mode == 1) ? ready_pat(cyc) : 1'b1;
            end
            @(negedge clk);
            if (rs) begin
                fcyc = cyc; r_pv = '0; r_nx = 0; r_nrd = 0; r_first = -1; r_last = -1;
            end else if (cyc > 0) begin
                if (ram_rd_en) begin
                    if (r_nrd < 8) r_addr[r_nrd] = ram_addr;
                    r_nrd++;
                end
                if (pix_valid && pix_ready) begin
                    r_pv = {r_pv[14:0], pix_out}; r_nx++; r_last = cyc - fcyc;
                end
                if (pix_valid && r_first < 0) r_first = cyc - fcyc;
                if (frame_done) r_done = cyc - fcyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        frame_start = 1'b0;
        chk("frame_completed", r_done >= 0, 1);
    endtask

    task automatic chk_addrs(input string name, input int a0, input int a1, input int a2, input int a3);
        chk({name, "_nrd"}, r_nrd, 4);
        chk({name, "_a0"}, r_addr[0], a0);
        chk({name, "_a1"}, r_addr[1], a1);
        chk({name, "_a2"}, r_addr[2], a2);
        chk({name, "_a3"}, r_addr[3], a3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n, guard, cyc, starve, rise;
        bit seen;
        for (int i = 0; i < 16; i++) begin
            mem[i]  = 4'(i * 7 + 1);
            mem1[i] = (i % 3 == 0);
        end
        mem[3] = 4'hA; mem[4] = 4'h5; mem[5] = 4'hF; mem[6] = 4'h0;
        mem[14] = 4'hA; mem[15] = 4'h5; mem[0] = 4'hF; mem[1] = 4'h0;

        rst = 1'b1; frame_start = 1'b0; frame_base = '0; pix_ready = 1'b0;
        fs1 = 1'b0; base1 = '0; ready1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rd_en", ram_rd_en, 0);
        chk("reset_addr", ram_addr, 0);
        chk("reset_pix_out", pix_out, 0);
        chk("reset_pix_valid", pix_valid, 0);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_underflow", underflow, 0);
        chk("reset_busy", busy, 0);
        chk("reset_busy1", busy1, 0);
        rst = 1'b0;
        mon_en = 1'b1;

        chk("model_pin_p0", exp_pix(3, 0), 1);
        chk("model_pin_p5", exp_pix(3, 5), 1);
        chk("model_pin_p15", exp_pix(3, 15), 0);
        chk("model_pin_wrap", exp_pix(14, 4), 0);

        run_frame(4'd3, 0, 0);
        chk("basic_pixels", r_pv, 16'hA5F0);
        chk("basic_count", r_nx, 16);
        chk("basic_first_valid", r_first, 3);
        chk("basic_done_cycle", r_done, 19);
        chk("basic_done_after_last", r_done, r_last + 1);
        chk_addrs("basic_addr", 3, 4, 5, 6);

        run_frame(4'd3, 1, 0);
        chk("stall_pixels", r_pv, 16'hA5F0);
        chk("stall_count", r_nx, 16);
        chk("stall_done_after_last", r_done, r_last + 1);
        chk_addrs("stall_addr", 3, 4, 5, 6);

        run_frame(4'd14, 0, 0);
        chk("wrap_pixels", r_pv, 16'hA5F0);
        chk_addrs("wrap_addr", 14, 15, 0, 1);

        run_frame(4'd3, 0, 6);
        chk("restart_taken", r_restarted, 1);
        chk("restart_pixels", r_pv, 16'hA5F0);
        chk("restart_count", r_nx, 16);
        chk("restart_first_valid", r_first, 3);
        chk("restart_done_after_last", r_done, r_last + 1);
        chk_addrs("restart_addr", 3, 4, 5, 6);

        frame_start = 1'b1; frame_base = 4'd3; pix_ready = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        n = 0; guard = 0;
        while (n < 9 && guard < 100) begin
            @(negedge clk);
            if (pix_valid && pix_ready) n++;
            @(posedge clk); #1;
            guard++;
        end
        chk("rst_mid_transfers", n, 9);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_rd_en", ram_rd_en, 0);
        chk("rst_mid_addr", ram_addr, 0);
        chk("rst_mid_pix_out", pix_out, 0);
        chk("rst_mid_pix_valid", pix_valid, 0);
        chk("rst_mid_frame_done", frame_done, 0);
        chk("rst_mid_underflow", underflow, 0);
        chk("rst_mid_busy", busy, 0);
        repeat (5) begin
            @(negedge clk);
            chk("rst_idle_rd_en", ram_rd_en, 0);
            chk("rst_idle_pix_valid", pix_valid, 0);
            chk("rst_idle_busy", busy, 0);
            @(posedge clk); #1;
        end

        ready1 = 1'b1; fs1 = 1'b1; base1 = 4'd0;
        @(posedge clk); #1;
        fs1 = 1'b0;
        cyc = 1; starve = -1; rise = -1; seen = 0;
        while (cyc < 40 && rise < 0) begin
            @(negedge clk);
            if (cyc <= 3) chk("uf_clear_in_fill", uf1, 0);
            if (valid1) seen = 1;
            if (seen && busy1 && !valid1 && starve < 0) starve = cyc;
            if (uf1) rise = cyc;
            @(posedge clk); #1;
            cyc++;
        end
        chk("uf_rise_cycle", rise, 6);
        chk("uf_after_starve", rise, starve + 1);
        ready1 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        @(negedge clk);
        chk("uf_sticky", uf1, 1);
        @(posedge clk); #1;
        fs1 = 1'b1;
        @(posedge clk); #1;
        fs1 = 1'b0;
        @(negedge clk);
        chk("uf_cleared", uf1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
